// File: rtl/mmio_gpio_port.sv
// Memory-mapped GPIO port: output/toggle registers, synchronized inputs with
// per-bit edge-detect status (W1C), interrupt enable and a registered level IRQ.

module mmio_gpio_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  input  logic edge_sel_i,
  input  logic clr_i,
  output logic in_o,
  output logic status_o
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_status;
  logic                   w_in;
  logic                   w_evt;

  assign w_in  = r_sync[SYNC_STAGES-1];
  assign w_evt = edge_sel_i ? (~w_in & r_prev) : (w_in & ~r_prev);

  // Set has priority over a simultaneous W1C clear so no event is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync   <= '0;
      r_prev   <= 1'b0;
      r_status <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], pin_i};
      r_prev   <= w_in;
      r_status <= (r_status & ~clr_i) | w_evt;
    end
  end

  assign in_o     = w_in;
  assign status_o = r_status;
endmodule

module mmio_gpio_port #(
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr_i,
  input  logic             we_i,
  input  logic [31:0]      write_data_i,
  output logic [31:0]      read_data_o,
  output logic             hit_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic             irq_o
);
  localparam logic [2:0] OFF_OUT    = 3'd0;
  localparam logic [2:0] OFF_IN     = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_IRQEN  = 3'd3;
  localparam logic [2:0] OFF_EDGE   = 3'd4;
  localparam logic [2:0] OFF_TOGGLE = 3'd5;

  logic             w_hit;
  logic [2:0]       w_off;
  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] w_status;
  logic [31:0]      w_rsel;
  logic             w_unused;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_irq_en;
  logic [WIDTH-1:0] r_edge_sel;
  logic [31:0]      r_rdata;
  logic             r_irq;

  assign w_hit    = (addr_i[31:5] == BASE_ADDR[31:5]);
  assign w_off    = addr_i[4:2];
  assign w_wr     = w_hit & we_i;
  assign w_rd     = w_hit & ~we_i;
  assign w_wdata  = write_data_i[WIDTH-1:0];
  assign w_clr    = (w_wr && w_off == OFF_STATUS) ? w_wdata : '0;
  // Byte-lane bits and data above WIDTH carry no meaning for this block.
  assign w_unused = ^{addr_i[1:0], write_data_i};

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    mmio_gpio_bit #(.SYNC_STAGES(SYNC_STAGES)) u_bit (
      .clk        (clk),
      .reset      (reset),
      .pin_i      (gpio_i[g]),
      .edge_sel_i (r_edge_sel[g]),
      .clr_i      (w_clr[g]),
      .in_o       (w_in[g]),
      .status_o   (w_status[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out      <= '0;
      r_irq_en   <= '0;
      r_edge_sel <= '0;
    end else if (w_wr) begin
      case (w_off)
        OFF_OUT:    r_out      <= w_wdata;
        OFF_IRQEN:  r_irq_en   <= w_wdata;
        OFF_EDGE:   r_edge_sel <= w_wdata;
        OFF_TOGGLE: r_out      <= r_out ^ w_wdata;
        default:    ;
      endcase
    end
  end

  always_comb begin
    w_rsel = '0;
    case (w_off)
      OFF_OUT:    w_rsel[WIDTH-1:0] = r_out;
      OFF_IN:     w_rsel[WIDTH-1:0] = w_in;
      OFF_STATUS: w_rsel[WIDTH-1:0] = w_status;
      OFF_IRQEN:  w_rsel[WIDTH-1:0] = r_irq_en;
      OFF_EDGE:   w_rsel[WIDTH-1:0] = r_edge_sel;
      default:    w_rsel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_rd) r_rdata <= w_rsel;
      r_irq <= |(w_status & r_irq_en);
    end
  end

  assign hit_o       = w_hit;
  assign gpio_o      = r_out;
  assign read_data_o = r_rdata;
  assign irq_o       = r_irq;
endmodule

// File: tb/tb_mmio_gpio_port.sv
// Directed bench for mmio_gpio_port (WIDTH=8, SYNC_STAGES=2): register map,
// toggle, edge/status/irq timing, W1C priority, address miss and reset.

module tb_mmio_gpio_port;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] read_data_o;
  logic        hit_o;
  logic [7:0]  gpio_i;
  logic [7:0]  gpio_o;
  logic        irq_o;

  int compared = 0;
  int mismatched = 0;

  mmio_gpio_port #(.WIDTH(8), .SYNC_STAGES(2), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr_i       (addr),
    .we_i         (we),
    .write_data_i (wdata),
    .read_data_o  (read_data_o),
    .hit_o        (hit_o),
    .gpio_i       (gpio_i),
    .gpio_o       (gpio_o),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] a(input int off);
    return BASE + 32'(off * 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    addr = a(off); we = 1'b1; wdata = d;
    @(negedge clk);
    we = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic rd(input string tag, input int off, input logic [31:0] exp);
    addr = a(off); we = 1'b0;
    @(negedge clk);
    chk(tag, read_data_o, exp);
    addr = 32'h0;
  endtask

  initial begin
    reset = 1'b0; addr = 32'h0; we = 1'b0; wdata = 32'h0; gpio_i = 8'h00;
    cyc(2);
    chk("rst_gpio_o", 32'(gpio_o), 32'h0);
    chk("rst_rdata", read_data_o, 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("hit_miss_zero", 32'(hit_o), 32'h0);
    addr = BASE + 32'h1F; #1;
    chk("hit_top_of_window", 32'(hit_o), 32'h1);
    addr = 32'h0;
    reset = 1'b1;

    // OUT write truncation and readback
    wr(0, 32'hFFFF_FFA5);
    chk("out_gpio_o", 32'(gpio_o), 32'hA5);
    rd("out_read", 0, 32'h0000_00A5);

    // TOGGLE
    wr(0, 32'h0F);
    wr(5, 32'hFF);
    chk("toggle_gpio_o", 32'(gpio_o), 32'hF0);
    rd("toggle_read", 5, 32'h0);

    // rising edge on bit 0: STATUS at t+3, irq at t+4
    wr(3, 32'h01);
    gpio_i = 8'h01;
    cyc(3);
    chk("irq_not_yet", 32'(irq_o), 32'h0);
    cyc(1);
    chk("irq_t4", 32'(irq_o), 32'h1);
    rd("status_bit0", 2, 32'h1);
    rd("status_read_no_clear", 2, 32'h1);
    wr(2, 32'h1);
    chk("irq_clear_edge", 32'(irq_o), 32'h1);
    cyc(1);
    chk("irq_after_clear", 32'(irq_o), 32'h0);
    rd("status_cleared", 2, 32'h0);

    // falling-edge select on bit 3
    wr(4, 32'h08);
    gpio_i = 8'h09;
    cyc(4);
    rd("fall_sel_rise_ignored", 2, 32'h0);
    gpio_i = 8'h01;
    cyc(4);
    rd("fall_sel_fall_sets", 2, 32'h8);
    chk("irq_masked_bit3", 32'(irq_o), 32'h0);
    wr(2, 32'h8);
    rd("bit3_cleared", 2, 32'h0);
    gpio_i = 8'h09;
    cyc(4);
    gpio_i = 8'h01;
    cyc(2);
    wr(2, 32'h8);
    rd("set_wins_over_clear", 2, 32'h8);

    // IN register, read-only, upper bits, read hold
    rd("in_read", 1, 32'h01);
    wr(1, 32'hFF);
    rd("in_write_ignored", 1, 32'h01);
    wr(4, 32'hFFFF_FF08);
    rd("edge_sel_trunc", 4, 32'h08);
    wr(0, 32'h11);
    chk("rdata_hold_on_write", read_data_o, 32'h08);
    chk("out_second_write", 32'(gpio_o), 32'h11);

    // address miss
    addr = a(8); we = 1'b1; wdata = 32'hFF; #1;
    chk("hit_base_plus_32", 32'(hit_o), 32'h0);
    @(negedge clk);
    we = 1'b0; addr = 32'h0;
    chk("miss_no_out_change", 32'(gpio_o), 32'h11);
    chk("miss_rdata_hold", read_data_o, 32'h08);
    rd("unmapped_off7", 7, 32'h0);

    // fill STATUS, then reset mid-operation with a competing write
    wr(4, 32'h0);
    wr(3, 32'hFF);
    gpio_i = 8'h00;
    cyc(4);
    gpio_i = 8'hFF;
    cyc(4);
    rd("status_all", 2, 32'hFF);
    chk("irq_before_reset", 32'(irq_o), 32'h1);
    reset = 1'b0; addr = a(0); we = 1'b1; wdata = 32'hAA; gpio_i = 8'h00;
    @(negedge clk);
    chk("reset_gpio_o", 32'(gpio_o), 32'h0);
    chk("reset_irq", 32'(irq_o), 32'h0);
    chk("reset_rdata", read_data_o, 32'h0);
    we = 1'b0; addr = 32'h0;
    reset = 1'b1;
    wr(0, 32'h3C);
    chk("first_write_after_reset", 32'(gpio_o), 32'h3C);
    cyc(6);
    rd("no_status_low_pins", 2, 32'h0);
    chk("no_irq_low_pins", 32'(irq_o), 32'h0);

    // pins held high through reset release
    reset = 1'b0; gpio_i = 8'hFF;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    rd("high_pins_pre_event", 2, 32'h0);
    rd("high_pins_event", 2, 32'hFF);
    chk("high_pins_irq_disabled", 32'(irq_o), 32'h0);
    wr(2, 32'hFF);
    rd("high_pins_sw_clear", 2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mmio_gpio_port.md
MMIO_GPIO_PORT -- requirements
Module: mmio_gpio_port

Interface
REQ-001 Parameter WIDTH, default 8, number of GPIO pins per direction; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth; legal range 2..4.
REQ-003 Parameter BASE_ADDR, default 32'h1001_0000, byte base address of the register window; 32-byte aligned.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-low reset; sampled on rising clk edge.
REQ-006 addr_i  input  32  byte address from the datapath address mux.
REQ-007 we_i  input  1  write strobe; write occurs on the clk edge where we_i=1 and address hits.
REQ-008 write_data_i  input  32  store data.
REQ-009 read_data_o  output  32  registered read data.
REQ-010 hit_o  output  1  combinational; 1 when addr_i[31:5]==BASE_ADDR[31:5].
REQ-011 gpio_i  input  WIDTH  asynchronous external pins.
REQ-012 gpio_o  output  WIDTH  registered output pins.
REQ-013 irq_o  output  1  registered level interrupt request.

Function
REQ-014 Register map, word offset addr_i[4:2]: 0 OUT (RW), 1 IN (RO), 2 STATUS (W1C), 3 IRQ_EN (RW), 4 EDGE_SEL (RW, bit=1 falling, 0 rising), 5 TOGGLE (WO); offsets 6-7 unmapped.
REQ-015 addr_i[1:0] ignored; all accesses are full-word.
REQ-016 Register bits above WIDTH-1 read as 0; write data above WIDTH-1 discarded.
REQ-017 gpio_o equals OUT register contents at all times.
REQ-018 Write to TOGGLE: OUT <= OUT ^ write_data_i[WIDTH-1:0] on the same edge; TOGGLE reads as 0.
REQ-019 Writes to IN, unmapped offsets, or with hit_o=0 have no effect.
REQ-020 gpio_i passes through SYNC_STAGES flops per bit; IN = last synchronizer stage; one further flop holds the previous IN (prev).
REQ-021 Edge detect per bit i: rise = IN[i]&~prev[i], fall = ~IN[i]&prev[i]; event[i] = EDGE_SEL[i] ? fall : rise.
REQ-022 STATUS[i] set to 1 on the edge after event[i]=1; holds until cleared.
REQ-023 Write to STATUS clears bits where write_data_i=1; event and clear on the same edge: set wins (bit stays 1).
REQ-024 Latency gpio_i change -> IN visible: SYNC_STAGES cycles; -> STATUS set: SYNC_STAGES+1 cycles; -> irq_o: SYNC_STAGES+2 cycles.
REQ-025 irq_o <= |(STATUS & IRQ_EN), registered, one cycle after STATUS/IRQ_EN update.
REQ-026 Read: read_data_o <= selected register (zero-extended) on every clk edge where hit_o=1 and we_i=0; value valid the cycle after address presentation.
REQ-027 Read of unmapped offset or TOGGLE yields 32'h0; when hit_o=0 or we_i=1 read_data_o holds its previous value.
REQ-028 Read of STATUS does not clear it.
REQ-029 Changing EDGE_SEL takes effect for events evaluated on the following edge; no spurious STATUS set from the change itself.

Reset
REQ-030 On reset=0 at a clk edge: OUT, STATUS, IRQ_EN, EDGE_SEL, read_data_o, irq_o, all synchronizer stages and prev <= 0.
REQ-031 Reset overrides any simultaneous write or event; first write accepted on the first edge with reset=1.
REQ-032 Pins held high through reset release produce a rising event SYNC_STAGES+1 cycles later as synchronizer fills; software clears it. This is required, specified behaviour.

Verification
REQ-033 WIDTH=8: write 32'hFFFF_FFA5 to OUT -> gpio_o=8'hA5 next cycle; read OUT -> read_data_o=32'h0000_00A5.
REQ-034 OUT=8'h0F, write 8'hFF to TOGGLE -> gpio_o=8'hF0; read TOGGLE -> 32'h0.
REQ-035 IRQ_EN=8'h01, EDGE_SEL=0, gpio_i[0] 0->1 at cycle t -> STATUS[0]=1 at t+3, irq_o=1 at t+4 (SYNC_STAGES=2); W1C 32'h1 -> irq_o=0 one cycle after clear.
REQ-036 EDGE_SEL[3]=1: gpio_i[3] rises -> STATUS[3] stays 0; falls -> STATUS[3]=1; clear written same cycle as new event -> STATUS[3] stays 1.
REQ-037 Write with addr_i=BASE_ADDR+32 -> hit_o=0, no register changes; read offset 7 -> 32'h0.
REQ-038 Assert reset=0 mid-operation with STATUS=8'hFF, irq_o=1 -> all outputs 0 after one edge; with reset=1, gpio_i held at 8'h00 -> no STATUS set.
